pipe_stage_buf: RTL
===================

# pipe_stage_buf

Parametrised elastic pipeline register for inter-stage boundaries of the THCOMIPS32e core, such as ID/EX, EX/MEM and MEM/WB. It carries a DATA_W-bit stage payload under a valid/ready handshake, with per-stage flush and stall. An optional 2-entry skid buffer gives full throughput with a registered `in_ready`. It replaces the fixed-format stage latches with one block instantiated per boundary.

## Interface
- DATA_W, 32: payload width in bits (≥1). Callers concatenate wd/wreg/wdata/aluop/addr fields into it.
- RST_DATA, 0: value loaded into `out_data` on reset and on flush.
- clk input 1: sole clock, rising edge.
- rst input 1: synchronous, active-low reset. It is sampled on `clk` rising edge; low = reset.
- flush input 1: discard all held and incoming payloads this cycle.
- stall input 1: freeze the stage; no transfer on either side.
- in_valid input 1: upstream payload valid.
- in_data input DATA_W: upstream payload.
- in_ready output 1: stage can accept.
- out_valid output 1: payload presented downstream.
- out_data output DATA_W: downstream payload.
- out_ready input 1: downstream accepts.
- count output 2: occupancy, 0..2 (0..1 without skid).

## Operation
- Input transfer (IT) = in_valid & in_ready. Output transfer (OT) = out_valid & out_ready.
- Storage is a main register M (drives out_data) and a skid register S, each with a valid bit.
- `in_ready = rst & !stall & !S.valid`. This is registered-state only, with no path from out_ready.
- `out_valid = M.valid & !stall`. out_data always shows M.data.
- Priority per edge: reset > flush > stall > normal.
- Reset (rst=0): M.valid=0, S.valid=0, M.data=RST_DATA, S.data=RST_DATA, count=0.
- Flush: same clearing as reset. An IT in the flush cycle is dropped. A flush during stall still clears.
- Stall: all state held. Upstream must hold in_data/in_valid.
- Normal update, evaluated in order:
  - OT & S.valid: M ← S, S.valid ← 0. No IT is possible because in_ready=0.
  - IT & (!M.valid | OT): M ← in_data, M.valid ← 1.
  - IT & M.valid & !OT: S ← in_data, S.valid ← 1.
  - OT & !IT & !S.valid: M.valid ← 0. M.data is retained (don't-care).
- Order is strictly FIFO. No payload is duplicated or lost except by flush or reset.
- count = M.valid + S.valid.

## Timing
- Latency: IT at edge n → out_valid=1 with that payload after edge n, i.e. 1 cycle.
- Throughput: 1 payload/cycle with out_ready held high.
- Backpressure: out_ready low with M full → one more payload is absorbed into S, then in_ready falls the cycle after.
- Release: out_ready high with count=2 → S moves to M at that edge. in_ready rises the following cycle.
- Boundary cases:
  - Empty: count=0 and out_valid=0.
  - Full: count=2 and in_ready=0.
  - Simultaneous IT+OT with count=1: M is replaced and count stays 1.
  - rst deasserting mid-stream: first accept can occur in the cycle after rst is high.
- Outputs during rst low: in_ready=0, out_valid=0, out_data=RST_DATA (after the first reset edge).

## Configuration
- Macro `PIPE_SKID_EN`, defined by default in defines.v.
- Defined: 2-entry behaviour above.
- Undefined: S and its logic are removed, count ≤ 1, and `in_ready = rst & !stall & (!M.valid | out_ready)`. This is a combinational path from out_ready. Throughput, latency, flush and stall rules are otherwise identical.

## Test plan
- Reset: rst=0 for 2 cycles with in_valid=1, in_data=0xDEAD → in_ready=0, out_valid=0, out_data=RST_DATA, count=0. After release, the first accept occurs the next cycle.
- Streaming: send 0x1..0x8 back-to-back with out_ready=1 → out_data shows 0x1..0x8 on 8 consecutive cycles, 1 cycle behind input.
- Backpressure (skid): out_ready=0 while sending 0xA, 0xB, 0xC → 0xA and 0xB accepted, count=2, in_ready=0. Raise out_ready → outputs 0xA, 0xB, 0xC in order with no loss.
- Flush: count=2 with 0x11/0x22 held, flush=1 while in_valid=1 with 0x33 → next cycle count=0, out_valid=0, out_data=RST_DATA. 0x33 is never output.
- Stall: stall=1 for 3 cycles with count=1 holding 0x55 and out_ready=1 → out_valid=0, in_ready=0, state held. Stall low → 0x55 is delivered once.
- Non-skid build (`PIPE_SKID_EN` undefined): count=1 holding 0x7, toggle out_ready 0→1 → in_ready follows out_ready in the same cycle, and count never exceeds 1.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - elastic valid/ready pipeline stage register with flush, stall and optional skid entry
//
// Purpose:
//   One instance sits on each core pipeline boundary (ID/EX, EX/MEM, MEM/WB).
//   The payload is an opaque DATA_W-bit vector under a valid/ready handshake.
//   Storage is a main register M, which drives out_data. With the skid
//   option there is also a second register S, which absorbs one extra
//   payload so that in_ready can be taken from registered state only.
//
// Configuration macro:
//   PIPE_SKID_EN  defined   -> 2-entry stage (M + S), in_ready has no path from out_ready
//                 undefined -> 1-entry stage (M only), in_ready = rst & !stall & (!M.valid | out_ready)
//
// Parameters:
//   DATA_W    payload width in bits (>= 1)
//   RST_DATA  value of out_data after reset and after flush
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous reset, active low
//   flush      in   discard held and incoming payloads this cycle
//   stall      in   freeze the stage, no transfer on either side
//   in_valid   in   upstream payload valid
//   in_data    in   upstream payload [DATA_W-1:0]
//   in_ready   out  stage can accept
//   out_valid  out  payload presented downstream
//   out_data   out  downstream payload [DATA_W-1:0] (always M.data)
//   out_ready  in   downstream accepts
//   count      out  occupancy [1:0], 0..2 (0..1 without skid)

module pipe_stage_buf #(
    parameter int                 DATA_W   = 32,
    parameter logic [DATA_W-1:0]  RST_DATA = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              stall,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [1:0]        count
);

    // Main register: the entry presented downstream.
    logic              m_valid_q;
    logic              m_valid_d;
    logic [DATA_W-1:0] m_data_q;
    logic [DATA_W-1:0] m_data_d;

    // Handshake events for this cycle.
    logic              in_xfer;
    logic              out_xfer;

    assign out_valid = m_valid_q & ~stall;
    assign out_data  = m_data_q;
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

`ifdef PIPE_SKID_EN

    // Skid register: holds the payload accepted while M was full and not
    // draining. Its valid bit is what deasserts in_ready, so backpressure
    // reaches upstream one cycle late and costs no bubble.
    logic              s_valid_q;
    logic              s_valid_d;
    logic [DATA_W-1:0] s_data_q;
    logic [DATA_W-1:0] s_data_d;

    // Registered state only: out_ready does not reach in_ready.
    assign in_ready = rst & ~stall & ~s_valid_q;
    assign count    = {1'b0, m_valid_q} + {1'b0, s_valid_q};

    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        s_valid_d = s_valid_q;
        s_data_d  = s_data_q;

        if (flush) begin
            // Held entries and any payload offered this cycle are dropped.
            m_valid_d = 1'b0;
            m_data_d  = RST_DATA;
            s_valid_d = 1'b0;
            s_data_d  = RST_DATA;
        end else if (!stall) begin
            if (out_xfer && s_valid_q) begin
                // S is the older payload; it refills M. in_ready is low
                // whenever S is valid, so no input transfer competes here.
                m_data_d  = s_data_q;
                s_valid_d = 1'b0;
            end else if (in_xfer && (!m_valid_q || out_xfer)) begin
                // M empty, or M leaving this edge: new payload goes straight to M.
                m_data_d  = in_data;
                m_valid_d = 1'b1;
            end else if (in_xfer && m_valid_q && !out_xfer) begin
                // M held downstream: park the payload in S.
                s_data_d  = in_data;
                s_valid_d = 1'b1;
            end else if (out_xfer) begin
                // Last entry left with nothing behind it; M.data is kept
                // as a don't-care.
                m_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            m_valid_q <= 1'b0;
            m_data_q  <= RST_DATA;
            s_valid_q <= 1'b0;
            s_data_q  <= RST_DATA;
        end else begin
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            s_valid_q <= s_valid_d;
            s_data_q  <= s_data_d;
        end
    end

`else

    // Single entry: the stage can accept when empty or when M drains on
    // this same edge, which makes in_ready combinational in out_ready.
    assign in_ready = rst & ~stall & (~m_valid_q | out_ready);
    assign count    = {1'b0, m_valid_q};

    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;

        if (flush) begin
            m_valid_d = 1'b0;
            m_data_d  = RST_DATA;
        end else if (!stall) begin
            if (in_xfer) begin
                // Covers both the empty case and the replace-while-draining case.
                m_data_d  = in_data;
                m_valid_d = 1'b1;
            end else if (out_xfer) begin
                m_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            m_valid_q <= 1'b0;
            m_data_q  <= RST_DATA;
        end else begin
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
        end
    end

`endif

endmodule
